// File: rtl/edge_stream_framer_pkg.sv
// Shared definitions for the edge_stream_framer slice: framer FSM states,
// the line sync byte and a width helper for counters and FIFO pointers.
package edge_stream_framer_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_HDR0,
      S_HDR1,
      S_HDR2,
      S_PAY,
      S_TRL
   } framer_state_t;

   localparam logic [7:0] LINE_SYNC = 8'hA5;

   // Bits needed to index n items, never less than 1.
   function automatic int unsigned clog2_min1(input int unsigned n);
      int unsigned w;
      w = 1;
      while ((64'd1 << w) < 64'(n)) w = w + 1;
      return w;
   endfunction

endpackage

// File: rtl/edge_stream_framer_sync_fifo.sv
// sync_fifo: single-clock FIFO with a registered read port.
// rd_data always holds the current head entry (valid whenever !empty); a pop
// advances it on the next edge, so back-to-back pops give one entry per clock.
// A push is accepted when not full, or when full and a pop happens this cycle.
// Ports:
//   clk, rst  clock, synchronous active-high reset (flushes the FIFO)
//   push      write request, wr_data is the entry
//   pop       read request (ignored when empty)
//   rd_data   head entry
//   full, empty, count  occupancy status
module sync_fifo
   import edge_stream_framer_pkg::*;
#(
   parameter int unsigned WIDTH = 8,
   parameter int unsigned DEPTH = 64
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           push,
   input  logic [WIDTH-1:0]               wr_data,
   input  logic                           pop,
   output logic [WIDTH-1:0]               rd_data,
   output logic                           full,
   output logic                           empty,
   output logic [clog2_min1(DEPTH):0]     count
);

   localparam int unsigned AW = clog2_min1(DEPTH);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic [AW-1:0]    rd_ptr_nxt;
   logic             pop_ok;
   logic             push_ok;

   always_comb begin
      full       = (count == (AW+1)'(DEPTH));
      empty      = (count == '0);
      pop_ok     = pop && !empty;
      push_ok    = push && (!full || pop_ok);
      rd_ptr_nxt = pop_ok ? rd_ptr + 1'b1 : rd_ptr;
   end

   always_ff @(posedge clk) begin
      if (push_ok) mem[wr_ptr] <= wr_data;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr  <= '0;
         rd_ptr  <= '0;
         count   <= '0;
         rd_data <= '0;
      end else begin
         if (push_ok) wr_ptr <= wr_ptr + 1'b1;
         rd_ptr <= rd_ptr_nxt;
         case ({push_ok, pop_ok})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Pre-fetch the next head; bypass the write when it lands on the
         // slot that becomes the head (FIFO empty after this edge's pop).
         if (push_ok && (wr_ptr == rd_ptr_nxt))
            rd_data <= wr_data;
         else
            rd_data <= mem[rd_ptr_nxt];
      end
   end

endmodule

// File: rtl/edge_stream_framer.sv
// edge_stream_framer: packs the free-running edge pixel stream into line
// packets (A5, row_hi, row_lo, IMG_W payload bytes) and closes each frame of
// IMG_H lines with an XOR checksum byte over the payload.
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   in_valid, in_pixel   input pixel stream, no backpressure
//   out_data, out_valid, out_ready, out_last   downlink byte handshake
//   frame_done           pulse the cycle after the checksum byte is accepted
//   overflow             sticky, set when a pixel was dropped on a full FIFO
module edge_stream_framer
   import edge_stream_framer_pkg::*;
#(
   parameter int unsigned IMG_W      = 3000,
   parameter int unsigned IMG_H      = 3000,
   parameter int unsigned FIFO_DEPTH = 64
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       in_valid,
   input  logic [7:0] in_pixel,
   output logic [7:0] out_data,
   output logic       out_valid,
   input  logic       out_ready,
   output logic       out_last,
   output logic       frame_done,
   output logic       overflow
);

   localparam int unsigned COL_W = clog2_min1(IMG_W);
   localparam int unsigned CNT_W = clog2_min1(FIFO_DEPTH) + 1;

   framer_state_t    state;
   logic [15:0]      row;
   logic [COL_W-1:0] col;
   logic [7:0]       csum;

   logic [7:0]       fifo_rd_data;
   logic             fifo_full;
   logic             fifo_empty;
   logic [CNT_W-1:0] fifo_count;
   logic             load;
   logic             pop;

   sync_fifo #(
      .WIDTH (8),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .push    (in_valid),
      .wr_data (in_pixel),
      .pop     (pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // The output register can take a new byte when it is empty or its current
   // byte is being accepted this cycle.
   always_comb begin
      load = !out_valid || out_ready;
      pop  = (state == S_PAY) && load && !fifo_empty;
   end

   // Header/payload states advance when their byte is loaded, which is the
   // same edge the previous byte is accepted; that keeps 1 byte/clk. The
   // trailer state holds until its own checksum byte is accepted.
   always_ff @(posedge clk) begin
      if (rst) begin
         state      <= S_IDLE;
         row        <= '0;
         col        <= '0;
         csum       <= '0;
         out_data   <= '0;
         out_valid  <= 1'b0;
         out_last   <= 1'b0;
         frame_done <= 1'b0;
         overflow   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (in_valid && fifo_full && !pop) overflow <= 1'b1;
         if (out_valid && out_ready) begin
            out_valid <= 1'b0;
            out_last  <= 1'b0;
         end

         case (state)
            S_IDLE: begin
               if (fifo_count != '0) state <= S_HDR0;
            end
            S_HDR0: begin
               if (load) begin
                  out_data  <= LINE_SYNC;
                  out_valid <= 1'b1;
                  state     <= S_HDR1;
               end
            end
            S_HDR1: begin
               if (load) begin
                  out_data  <= row[15:8];
                  out_valid <= 1'b1;
                  state     <= S_HDR2;
               end
            end
            S_HDR2: begin
               if (load) begin
                  out_data  <= row[7:0];
                  out_valid <= 1'b1;
                  state     <= S_PAY;
               end
            end
            S_PAY: begin
               if (pop) begin
                  out_data  <= fifo_rd_data;
                  out_valid <= 1'b1;
                  csum      <= csum ^ fifo_rd_data;
                  if (col == COL_W'(IMG_W - 1)) begin
                     col <= '0;
                     if (row == 16'(IMG_H - 1)) begin
                        state <= S_TRL;
                     end else begin
                        row   <= row + 16'd1;
                        state <= S_HDR0;
                     end
                  end else begin
                     col <= col + 1'b1;
                  end
               end
            end
            S_TRL: begin
               if (out_valid && out_last) begin
                  if (out_ready) begin
                     frame_done <= 1'b1;
                     row        <= '0;
                     csum       <= '0;
                     state      <= S_IDLE;
                  end
               end else if (load) begin
                  out_data  <= csum;
                  out_valid <= 1'b1;
                  out_last  <= 1'b1;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_edge_stream_framer.sv
// Self-checking bench for edge_stream_framer (IMG_W=4, IMG_H=2, FIFO_DEPTH=8).
// Expected downlink bytes are generated from the list of accepted pixels by
// the packet format rules (headers, payload, XOR trailer).
module tb_edge_stream_framer;

   localparam int W = 4;
   localparam int H = 2;
   localparam int D = 8;

   logic       clk = 1'b0;
   logic       rst;
   logic       in_valid;
   logic [7:0] in_pixel;
   logic [7:0] out_data;
   logic       out_valid;
   logic       out_ready;
   logic       out_last;
   logic       frame_done;
   logic       overflow;

   always #5 clk = ~clk;

   edge_stream_framer #(
      .IMG_W      (W),
      .IMG_H      (H),
      .FIFO_DEPTH (D)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .in_valid   (in_valid),
      .in_pixel   (in_pixel),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_last   (out_last),
      .frame_done (frame_done),
      .overflow   (overflow)
   );

   int checks = 0;
   int errors = 0;

   logic [7:0] got_data[$];
   logic       got_last[$];
   logic [7:0] exp_data[$];
   logic       exp_last[$];
   logic [7:0] sent_px[$];
   int         done_cnt = 0;
   int unsigned ready_mode = 0;   // 0 always, 1 toggle, 2 random, 3 hold low

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Downlink readiness driver.
   initial begin
      out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         case (ready_mode)
            0:       out_ready = 1'b1;
            1:       out_ready = ~out_ready;
            2:       out_ready = 1'($urandom_range(0, 1));
            default: out_ready = 1'b0;
         endcase
      end
   end

   // Monitor: sampled mid-cycle; a byte with valid&&ready is taken at the next edge.
   logic       prev_stall = 1'b0;
   logic [7:0] prev_data;
   logic       prev_last;
   always @(negedge clk) begin
      if (rst) begin
         prev_stall = 1'b0;
      end else begin
         if (prev_stall) begin
            chk("stall_valid", out_valid, 1'b1);
            chk("stall_data", out_data, prev_data);
            chk("stall_last", out_last, prev_last);
         end
         if (out_valid && out_ready) begin
            got_data.push_back(out_data);
            got_last.push_back(out_last);
         end
         if (frame_done) done_cnt++;
         prev_stall = out_valid && !out_ready;
         prev_data  = out_data;
         prev_last  = out_last;
      end
   end

   // Stream position of payload pixel q, counted from a frame start.
   function automatic int pos_of(input int q);
      int k;
      k = q % (W * H);
      return (q / (W * H)) * (H * (W + 3) + 1) + (k / W) * (W + 3) + 3 + (k % W);
   endfunction

   task automatic build_expected();
      int nf;
      logic [7:0] x;
      logic [7:0] v;
      exp_data.delete();
      exp_last.delete();
      nf = sent_px.size() / (W * H);
      for (int f = 0; f < nf; f++) begin
         x = 8'h00;
         for (int r = 0; r < H; r++) begin
            exp_data.push_back(8'hA5);          exp_last.push_back(1'b0);
            exp_data.push_back(8'((r >> 8) & 255)); exp_last.push_back(1'b0);
            exp_data.push_back(8'(r & 255));    exp_last.push_back(1'b0);
            for (int c = 0; c < W; c++) begin
               v = sent_px[f * W * H + r * W + c];
               exp_data.push_back(v);
               exp_last.push_back(1'b0);
               x = x ^ v;
            end
         end
         exp_data.push_back(x);
         exp_last.push_back(1'b1);
      end
   endtask

   task automatic clear_logs();
      got_data.delete();
      got_last.delete();
      sent_px.delete();
      done_cnt = 0;
   endtask

   task automatic do_reset(input bit check);
      rst = 1'b1;
      in_valid = 1'b0;
      repeat (2) begin @(posedge clk); #1; end
      if (check) begin
         chk("rst_out_data", out_data, 8'h00);
         chk("rst_out_valid", out_valid, 1'b0);
         chk("rst_out_last", out_last, 1'b0);
         chk("rst_frame_done", frame_done, 1'b0);
         chk("rst_overflow", overflow, 1'b0);
      end
      rst = 1'b0;
   endtask

   task automatic send(input logic [7:0] base, input int n, input bit rnd,
                       input bit throttle, input bit gaps);
      for (int p = 0; p < n; p++) begin
         int c;
         logic [7:0] v;
         in_valid = 1'b0;
         if (gaps) repeat ($urandom_range(0, 3)) begin @(posedge clk); #1; end
         c = 0;
         while (throttle && p >= 6 && got_data.size() < pos_of(p - 6) + 1 && c < 500) begin
            @(posedge clk); #1;
            c++;
         end
         v = rnd ? 8'($urandom) : base + 8'(p);
         in_valid = 1'b1;
         in_pixel = v;
         sent_px.push_back(v);
         @(posedge clk); #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic wait_bytes(input int n, input int budget);
      int c;
      c = 0;
      while (got_data.size() < n && c < budget) begin
         @(posedge clk); #1;
         c++;
      end
      chk("bytes_arrived", got_data.size() >= n, 1'b1);
   endtask

   task automatic compare_stream();
      int n;
      repeat (4) begin @(posedge clk); #1; end
      chk("stream_len", got_data.size(), exp_data.size());
      n = (got_data.size() < exp_data.size()) ? got_data.size() : exp_data.size();
      for (int i = 0; i < n; i++) begin
         chk($sformatf("byte[%0d]", i), got_data[i], exp_data[i]);
         chk($sformatf("last[%0d]", i), got_last[i], exp_last[i]);
      end
   endtask

   typedef struct {
      logic [7:0]  base;
      int          npix;
      int unsigned rmode;
      bit          rnd;
      int          exp_frames;
      logic [7:0]  exp_csum;
   } vec_t;

   vec_t vecs[6];

   initial begin
      #2_000_000;
      errors++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b1;
      in_valid = 1'b0;
      in_pixel = 8'h00;

      vecs[0] = '{base: 8'h01, npix: 8,  rmode: 0, rnd: 1'b0, exp_frames: 1, exp_csum: 8'h08};
      vecs[1] = '{base: 8'h01, npix: 8,  rmode: 1, rnd: 1'b0, exp_frames: 1, exp_csum: 8'h08};
      vecs[2] = '{base: 8'h01, npix: 16, rmode: 0, rnd: 1'b0, exp_frames: 2, exp_csum: 8'h18};
      vecs[3] = '{base: 8'h20, npix: 8,  rmode: 2, rnd: 1'b0, exp_frames: 1, exp_csum: 8'h00};
      vecs[4] = '{base: 8'h00, npix: 24, rmode: 2, rnd: 1'b1, exp_frames: 3, exp_csum: 8'h00};
      vecs[5] = '{base: 8'h00, npix: 16, rmode: 1, rnd: 1'b1, exp_frames: 2, exp_csum: 8'h00};

      @(posedge clk); #1;

      // Reset values, then idle with no input.
      ready_mode = 0;
      do_reset(1'b1);
      repeat (4) begin
         @(posedge clk); #1;
         chk("idle_out_valid", out_valid, 1'b0);
      end

      // First-byte latency into an empty idle framer.
      clear_logs();
      in_valid = 1'b1;
      in_pixel = 8'h55;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("lat_k0_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      chk("lat_k1_valid", out_valid, 1'b0);
      @(posedge clk); #1;
      chk("lat_k2_valid", out_valid, 1'b1);
      chk("lat_k2_data", out_data, 8'hA5);

      // Table-driven streams.
      foreach (vecs[i]) begin
         ready_mode = vecs[i].rmode;
         do_reset(1'b0);
         clear_logs();
         send(vecs[i].base, vecs[i].npix, vecs[i].rnd,
              vecs[i].rmode == 2 || vecs[i].rnd, vecs[i].rmode == 2);
         build_expected();
         wait_bytes(exp_data.size(), 3000);
         compare_stream();
         chk($sformatf("vec%0d_frames", i), done_cnt, vecs[i].exp_frames);
         chk($sformatf("vec%0d_overflow", i), overflow, 1'b0);
         if (!vecs[i].rnd && got_data.size() > 0)
            chk($sformatf("vec%0d_csum", i), got_data[got_data.size() - 1], vecs[i].exp_csum);
      end

      // Overflow: downlink stalled, nine pixels into an 8-entry FIFO.
      ready_mode = 3;
      do_reset(1'b0);
      clear_logs();
      send(8'h10, 8, 1'b0, 1'b0, 1'b0);
      chk("ovf_before", overflow, 1'b0);
      in_valid = 1'b1;
      in_pixel = 8'h18;
      @(posedge clk); #1;
      in_valid = 1'b0;
      chk("ovf_after", overflow, 1'b1);
      ready_mode = 0;
      build_expected();
      wait_bytes(exp_data.size(), 500);
      compare_stream();
      chk("ovf_frames", done_cnt, 1);
      chk("ovf_sticky", overflow, 1'b1);

      // Reset in the middle of a frame.
      ready_mode = 0;
      do_reset(1'b0);
      clear_logs();
      send(8'h30, 3, 1'b0, 1'b0, 1'b0);
      wait_bytes(2, 100);
      rst = 1'b1;
      @(posedge clk); #1;
      chk("midrst_out_data", out_data, 8'h00);
      chk("midrst_out_valid", out_valid, 1'b0);
      chk("midrst_out_last", out_last, 1'b0);
      chk("midrst_frame_done", frame_done, 1'b0);
      @(posedge clk); #1;
      rst = 1'b0;
      clear_logs();
      send(8'h41, 8, 1'b0, 1'b0, 1'b0);
      build_expected();
      wait_bytes(exp_data.size(), 500);
      compare_stream();
      chk("midrst_frames", done_cnt, 1);
      if (got_data.size() > 0)
         chk("midrst_csum", got_data[got_data.size() - 1], 8'h08);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
